// File: rtl/button_conditioner.sv
// Three-bit push-button conditioner: 2-flop synchroniser, per-bit debounce FSM,
// registered clean levels plus one-cycle rise/fall pulses.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:1] btn_raw,
  output logic [3:1] b,
  output logic [3:1] b_rise,
  output logic [3:1] b_fall
);

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    WAIT_HI = 2'd1,
    HIGH    = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:1]       s0, s1;
  state_t           state     [3:1];
  state_t           state_nxt [3:1];
  logic [CNT_W-1:0] cnt       [3:1];
  logic [CNT_W-1:0] cnt_nxt   [3:1];
  logic [3:1]       b_nxt, rise_nxt, fall_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= '0;
      s1 <= '0;
    end else begin
      s0 <= btn_raw;
      s1 <= s0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i <= 3; i++) begin
        state[i] <= LOW;
        cnt[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 1; i <= 3; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  // The first qualifying cycle is the one that leaves LOW/HIGH, so the count starts at 1.
  always_comb begin
    for (int unsigned i = 1; i <= 3; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = '0;
      case (state[i])
        LOW: begin
          if (s1[i]) begin
            state_nxt[i] = WAIT_HI;
            cnt_nxt[i]   = CNT_ONE;
          end
        end
        WAIT_HI: begin
          if (!s1[i]) begin
            state_nxt[i] = LOW;
          end else if (cnt[i] == CNT_MAX) begin
            state_nxt[i] = HIGH;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_ONE;
          end
        end
        HIGH: begin
          if (!s1[i]) begin
            state_nxt[i] = WAIT_LO;
            cnt_nxt[i]   = CNT_ONE;
          end
        end
        WAIT_LO: begin
          if (s1[i]) begin
            state_nxt[i] = HIGH;
          end else if (cnt[i] == CNT_MAX) begin
            state_nxt[i] = LOW;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_ONE;
          end
        end
        default: begin
          state_nxt[i] = LOW;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so b never glitches.
  always_comb begin
    b_nxt    = '0;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int unsigned i = 1; i <= 3; i++) begin
      b_nxt[i]    = (state_nxt[i] == HIGH) || (state_nxt[i] == WAIT_LO);
      rise_nxt[i] = (state[i] == WAIT_HI) && (state_nxt[i] == HIGH);
      fall_nxt[i] = (state[i] == WAIT_LO) && (state_nxt[i] == LOW);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b      <= '0;
      b_rise <= '0;
      b_fall <= '0;
    end else begin
      b      <= b_nxt;
      b_rise <= rise_nxt;
      b_fall <= fall_nxt;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus queues expected output events
// with their cycle numbers; a negedge monitor checks every cycle against them.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:1] btn_raw;
  logic [3:1] b, b_rise, b_fall;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int unsigned at;
    logic [3:1]  b;
    logic [3:1]  r;
    logic [3:1]  f;
  } ev_t;

  ev_t        q[$];
  logic [3:1] mon_b = '0;

  button_conditioner #(.DEBOUNCE_CYCLES(16), .CNT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_raw),
    .b       (b),
    .b_rise  (b_rise),
    .b_fall  (b_fall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [3:1] act, input logic [3:1] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned at, input logic [3:1] eb,
                      input logic [3:1] er, input logic [3:1] ef);
    ev_t e;
    e.at = at; e.b = eb; e.r = er; e.f = ef;
    q.push_back(e);
  endtask

  task automatic set_btn(input logic [3:1] v);
    @(negedge clk);
    btn_raw = v;
  endtask

  task automatic hold(input logic [3:1] v, input int n);
    set_btn(v);
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: events at their scheduled cycle, quiet and stable outputs otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_b", b, 3'b000);
      chk("reset_rise", b_rise, 3'b000);
      chk("reset_fall", b_fall, 3'b000);
      mon_b = '0;
    end else if (q.size() != 0 && q[0].at == cyc) begin
      ev_t e;
      e = q.pop_front();
      chk("event_b", b, e.b);
      chk("event_rise", b_rise, e.r);
      chk("event_fall", b_fall, e.f);
      mon_b = e.b;
    end else begin
      chk("quiet_b", b, mon_b);
      chk("quiet_rise", b_rise, 3'b000);
      chk("quiet_fall", b_fall, 3'b000);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    rst_n   = 1'b0;
    btn_raw = 3'b111;

    // Reset held with all buttons pressed.
    idle(4);
    set_btn(3'b000);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // Clean press on bit 1: 17 edges after sampling.
    set_btn(3'b001);
    k = cyc + 1;
    push(k + 17, 3'b001, 3'b001, 3'b000);
    idle(25);

    // Bit 2 bounces with 3-cycle pulses, then settles high.
    hold(3'b011, 3);
    hold(3'b001, 3);
    hold(3'b011, 3);
    hold(3'b001, 3);
    set_btn(3'b011);
    k = cyc + 1;
    push(k + 17, 3'b011, 3'b010, 3'b000);
    idle(25);

    // 15-cycle glitch on bit 3 is rejected.
    hold(3'b111, 15);
    hold(3'b011, 25);

    // 16-cycle pulse on bit 3 is accepted, then released.
    set_btn(3'b111);
    k = cyc + 1;
    push(k + 17, 3'b111, 3'b100, 3'b000);
    push(k + 33, 3'b011, 3'b000, 3'b100);
    idle(15);
    set_btn(3'b011);
    idle(25);

    // Release all, then 000 -> 101 in one cycle.
    set_btn(3'b000);
    k = cyc + 1;
    push(k + 17, 3'b000, 3'b000, 3'b011);
    idle(25);
    set_btn(3'b101);
    k = cyc + 1;
    push(k + 17, 3'b101, 3'b101, 3'b000);
    idle(25);

    // Simultaneous fall on bits 1,3 and rise on bit 2.
    set_btn(3'b010);
    k = cyc + 1;
    push(k + 17, 3'b010, 3'b010, 3'b101);
    idle(25);

    // Reset while bit 1 is in WAIT_HI and b=010 is held.
    set_btn(3'b011);
    idle(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_b", b, 3'b000);
    chk("async_reset_rise", b_rise, 3'b000);
    chk("async_reset_fall", b_fall, 3'b000);
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    k = cyc + 1;
    push(k + 17, 3'b011, 3'b011, 3'b000);
    idle(25);

    set_btn(3'b000);
    k = cyc + 1;
    push(k + 17, 3'b000, 3'b000, 3'b011);
    idle(25);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
